// File: rtl/nonrestoring_divider_w_if.sv
// Operand/result bundle for the sequential non-restoring divider.
// The master side issues operations; the slave side is the divider itself.
interface nonrestoring_divider_w_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/nonrestoring_divider_w.sv
// Parametrised sequential non-restoring divider (quotient + remainder).
// Signed operation divides magnitudes and fixes signs afterwards, so the
// quotient truncates toward zero and the remainder follows the dividend.
module nonrestoring_divider_w #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    nonrestoring_divider_w_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ITER    = 3'd2,
        CORRECT = 3'd3,
        FIX     = 3'd4
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic             signed_r;
    logic [WIDTH:0]   a_r;        // partial remainder, two's complement
    logic [WIDTH-1:0] q_r;        // dividend magnitude shifting into quotient
    logic [WIDTH-1:0] m_r;        // divisor magnitude
    logic [CNT_W-1:0] cnt_r;
    logic             q_neg_r;
    logic             r_neg_r;

    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   a_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic             ovf_s;

    // Magnitude as an unsigned WIDTH-bit value; -2^(WIDTH-1) maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic             is_signed);
        logic [WIDTH-1:0] result;
        if (is_signed && value[WIDTH-1]) begin
            result = -value;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // One non-restoring step: shift {A,Q}, then subtract or add M by A's sign.
    always_comb begin
        shift_s = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
        if (!a_r[WIDTH]) begin
            a_step_s = shift_s - {1'b0, m_r};
        end else begin
            a_step_s = shift_s + {1'b0, m_r};
        end
        q_step_s = {q_r[WIDTH-2:0], ~a_step_s[WIDTH]};
    end

    // Most-negative / -1 is the only signed quotient that cannot be represented.
    always_comb begin
        if (signed_r && (dividend_r == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor_r)) begin
            ovf_s = 1'b1;
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= IDLE;
            dividend_r      <= '0;
            divisor_r       <= '0;
            signed_r        <= 1'b0;
            a_r             <= '0;
            q_r             <= '0;
            m_r             <= '0;
            cnt_r           <= '0;
            q_neg_r         <= 1'b0;
            r_neg_r         <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        dividend_r <= bus.dividend;
                        divisor_r  <= bus.divisor;
                        signed_r   <= bus.signed_mode;
                        bus.busy   <= 1'b1;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    if (divisor_r == '0) begin
                        // Divide by zero finishes here without iterating.
                        bus.quotient    <= '1;
                        bus.remainder   <= dividend_r;
                        bus.div_by_zero <= 1'b1;
                        bus.overflow    <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                        state_r         <= IDLE;
                    end else begin
                        a_r     <= '0;
                        q_r     <= magnitude(dividend_r, signed_r);
                        m_r     <= magnitude(divisor_r, signed_r);
                        cnt_r   <= '0;
                        q_neg_r <= signed_r & (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]);
                        r_neg_r <= signed_r & dividend_r[WIDTH-1];
                        state_r <= ITER;
                    end
                end
                ITER: begin
                    a_r   <= a_step_s;
                    q_r   <= q_step_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= CORRECT;
                    end
                end
                CORRECT: begin
                    // A negative final partial remainder is restored once.
                    if (a_r[WIDTH]) begin
                        a_r <= a_r + {1'b0, m_r};
                    end
                    state_r <= FIX;
                end
                FIX: begin
                    if (ovf_s) begin
                        bus.quotient  <= {1'b1, {(WIDTH-1){1'b0}}};
                        bus.remainder <= '0;
                        bus.overflow  <= 1'b1;
                    end else begin
                        bus.quotient  <= q_neg_r ? -q_r : q_r;
                        bus.remainder <= r_neg_r ? -a_r[WIDTH-1:0] : a_r[WIDTH-1:0];
                        bus.overflow  <= 1'b0;
                    end
                    bus.div_by_zero <= 1'b0;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state_r         <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider_w.sv
// Self-checking bench for nonrestoring_divider_w at WIDTH 8, 16 and 32.
// Expected results (values and done cycle) are queued when an operation is
// issued and compared by per-instance monitors when done pulses.
module tb_nonrestoring_divider_w;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        bit          dbz;
        bit          ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        bit         sm;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        bit         dbz;
        bit         ovf;
    } vec_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q32[$];

    logic [7:0] hold_q = 8'd0;
    logic [7:0] hold_r = 8'd0;
    logic       hold_dbz = 1'b0;
    logic       hold_ovf = 1'b0;

    nonrestoring_divider_w_if #(.WIDTH(8))  if8 ();
    nonrestoring_divider_w_if #(.WIDTH(16)) if16 ();
    nonrestoring_divider_w_if #(.WIDTH(32)) if32 ();

    nonrestoring_divider_w #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    nonrestoring_divider_w #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    nonrestoring_divider_w #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_res(input string pfx, input exp_t e, input logic [63:0] q,
                             input logic [63:0] r, input logic dbz, input logic ovf,
                             input logic busy);
        chk({pfx, "_quotient"}, q, e.q);
        chk({pfx, "_remainder"}, r, e.r);
        chk({pfx, "_div_by_zero"}, {63'd0, dbz}, {63'd0, e.dbz});
        chk({pfx, "_overflow"}, {63'd0, ovf}, {63'd0, e.ovf});
        chk({pfx, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
        chk({pfx, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    endtask

    // Truncating reference built on native 64-bit arithmetic.
    function automatic exp_t ref_div(input int w, input bit sm,
                                     input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        longint      sa;
        longint      sb;
        exp_t        e;
        mask  = (64'd1 << w) - 64'd1;
        a     = a_in & mask;
        b     = b_in & mask;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.cyc = 0;
        if (b == 64'd0) begin
            e.q   = mask;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (sm) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            if (sa == -(longint'(1) <<< (w - 1)) && sb == -64'sd1) begin
                e.ovf = 1'b1;
                e.q   = 64'd1 << (w - 1);
                e.r   = 64'd0;
            end else begin
                e.q = 64'(sa / sb) & mask;
                e.r = 64'(sa % sb) & mask;
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    function automatic int qsize(input int w);
        case (w)
            8:       return q8.size();
            16:      return q16.size();
            default: return q32.size();
        endcase
    endfunction

    // Issue one operation; expected done cycle derives from the spec latency.
    task automatic drive(input int w, input bit sm, input logic [63:0] a,
                         input logic [63:0] b, input exp_t e_in);
        exp_t e;
        e     = e_in;
        e.cyc = cyc + 1 + (e.dbz ? 1 : w + 3);
        case (w)
            8: begin
                if8.signed_mode = sm; if8.dividend = a[7:0]; if8.divisor = b[7:0];
                if8.start = 1'b1; q8.push_back(e);
            end
            16: begin
                if16.signed_mode = sm; if16.dividend = a[15:0]; if16.divisor = b[15:0];
                if16.start = 1'b1; q16.push_back(e);
            end
            default: begin
                if32.signed_mode = sm; if32.dividend = a[31:0]; if32.divisor = b[31:0];
                if32.start = 1'b1; q32.push_back(e);
            end
        endcase
        @(posedge clk); #2;
        if8.start = 1'b0;  if16.start = 1'b0;  if32.start = 1'b0;
        if8.dividend  = 8'($urandom);  if8.divisor  = 8'($urandom);  if8.signed_mode  = ~sm;
        if16.dividend = 16'($urandom); if16.divisor = 16'($urandom); if16.signed_mode = ~sm;
        if32.dividend = $urandom;      if32.divisor = $urandom;      if32.signed_mode = ~sm;
    endtask

    task automatic wait_idle(input int w);
        int n;
        n = 0;
        while (qsize(w) != 0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (qsize(w) != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_w%0d pending=%0d required=0", w, qsize(w));
            case (w)
                8:       q8.delete();
                16:      q16.delete();
                default: q32.delete();
            endcase
        end
        @(posedge clk); #2;
    endtask

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0:       return mask;
            1:       return 64'd1 << (w - 1);
            2:       return 64'd0;
            3:       return 64'd1;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    // WIDTH=8 monitor: scoreboard compare on done, results must hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            hold_q <= 8'd0; hold_r <= 8'd0; hold_dbz <= 1'b0; hold_ovf <= 1'b0;
        end else if (if8.done) begin
            if (q8.size() == 0) begin
                checks++; failures++;
                $display("FAIL w8_unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                e = q8.pop_front();
                check_res("w8", e, 64'(if8.quotient), 64'(if8.remainder),
                          if8.div_by_zero, if8.overflow, if8.busy);
                hold_q <= e.q[7:0]; hold_r <= e.r[7:0];
                hold_dbz <= e.dbz;  hold_ovf <= e.ovf;
            end
        end else begin
            chk("w8_hold_quotient", 64'(if8.quotient), 64'(hold_q));
            chk("w8_hold_remainder", 64'(if8.remainder), 64'(hold_r));
            chk("w8_hold_flags", {62'd0, if8.div_by_zero, if8.overflow}, {62'd0, hold_dbz, hold_ovf});
        end
    end

    // WIDTH=16 monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst && if16.done) begin
            if (q16.size() == 0) begin
                checks++; failures++;
                $display("FAIL w16_unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                e = q16.pop_front();
                check_res("w16", e, 64'(if16.quotient), 64'(if16.remainder),
                          if16.div_by_zero, if16.overflow, if16.busy);
            end
        end
    end

    // WIDTH=32 monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst && if32.done) begin
            if (q32.size() == 0) begin
                checks++; failures++;
                $display("FAIL w32_unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                e = q32.pop_front();
                check_res("w32", e, 64'(if32.quotient), 64'(if32.remainder),
                          if32.div_by_zero, if32.overflow, if32.busy);
            end
        end
    end

    initial begin
        vec_t tbl[14];
        exp_t e;
        int   widths[3];

        tbl[0]  = '{1'b0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'd200, 8'd0,   8'hFF,  8'hC8,  1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'hF9,  8'hFE,  8'h03,  8'hFF,  1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1};
        tbl[9]  = '{1'b1, 8'h80,  8'h02,  8'hC0,  8'h00,  1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h85,  8'h00,  8'hFF,  8'h85,  1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'hFF,  8'hFF,  8'h01,  8'h00,  1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'hFE,  8'h7F,  8'h02,  8'h00,  1'b0, 1'b0};

        if8.start = 1'b0;  if8.signed_mode = 1'b0;  if8.dividend = 8'd0;  if8.divisor = 8'd0;
        if16.start = 1'b0; if16.signed_mode = 1'b0; if16.dividend = 16'd0; if16.divisor = 16'd0;
        if32.start = 1'b0; if32.signed_mode = 1'b0; if32.dividend = 32'd0; if32.divisor = 32'd0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(if8.busy), 64'd0);
        chk("reset_done", 64'(if8.done), 64'd0);
        chk("reset_quotient", 64'(if8.quotient), 64'd0);
        chk("reset_remainder", 64'(if8.remainder), 64'd0);
        chk("reset_flags", {62'd0, if8.div_by_zero, if8.overflow}, 64'd0);
        chk("reset_w32_quotient", 64'(if32.quotient), 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;

        // Directed vectors at WIDTH=8.
        for (int i = 0; i < 14; i++) begin
            e.q = 64'(tbl[i].q); e.r = 64'(tbl[i].r);
            e.dbz = tbl[i].dbz;  e.ovf = tbl[i].ovf; e.cyc = 0;
            drive(8, tbl[i].sm, 64'(tbl[i].a), 64'(tbl[i].b), e);
            wait_idle(8);
        end

        // start held high for 20 cycles: one op, then a second accepted in the done cycle.
        if8.signed_mode = 1'b0; if8.dividend = 8'd100; if8.divisor = 8'd7; if8.start = 1'b1;
        e = '{64'd14, 64'd2, 1'b0, 1'b0, cyc + 1 + 11};
        q8.push_back(e);
        e.cyc = cyc + 1 + 12 + 11;
        q8.push_back(e);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (i == 5) chk("held_start_busy", 64'(if8.busy), 64'd1);
        end
        if8.start = 1'b0;
        wait_idle(8);

        // Reset during iteration 4 aborts with no done; next op runs clean.
        e = '{64'd14, 64'd2, 1'b0, 1'b0, 0};
        drive(8, 1'b0, 64'd100, 64'd7, e);
        repeat (4) begin @(posedge clk); #2; end
        chk("abort_busy_before", 64'(if8.busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(if8.busy), 64'd0);
        chk("abort_done", 64'(if8.done), 64'd0);
        chk("abort_quotient", 64'(if8.quotient), 64'd0);
        chk("abort_remainder", 64'(if8.remainder), 64'd0);
        q8.delete();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (20) begin @(posedge clk); #2; end
        chk("abort_busy_after", 64'(if8.busy), 64'd0);
        e = '{64'd14, 64'd2, 1'b0, 1'b0, 0};
        drive(8, 1'b0, 64'd100, 64'd7, e);
        wait_idle(8);

        // Random regression against the reference model, both modes.
        widths[0] = 8; widths[1] = 16; widths[2] = 32;
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 60; n++) begin
                logic [63:0] a;
                logic [63:0] b;
                bit          sm;
                a  = pick(widths[k]);
                b  = pick(widths[k]);
                sm = 1'($urandom_range(0, 1));
                if (n < 4) begin
                    a  = 64'd1 << (widths[k] - 1);
                    b  = (n[0]) ? ((64'd1 << widths[k]) - 64'd1) : 64'd1;
                    sm = n[1];
                end
                e = ref_div(widths[k], sm, a, b);
                drive(widths[k], sm, a, b, e);
                wait_idle(widths[k]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
